// File: rtl/instruction_pkg.sv
// Shared types and default sizing for the data-memory responder.
package instruction_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } dm_state_e;

  localparam int DM_ADDR_W = 14;
  localparam int DM_DEPTH  = 16384;

  // Index width for an array of the given depth, never narrower than one bit.
  function automatic int dm_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_if.sv
// CPU data-memory port plus preload port of the responder.
interface dm_if #(
  parameter int ADDR_W = 14
);
  logic              dm_ceb;
  logic              dm_w_en;
  logic [31:0]       dm_bweb;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic [31:0]       dm_dout;
  logic              load_mode;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              busy;

  modport master (
    output dm_ceb, dm_w_en, dm_bweb, dm_addr, dm_din,
    output load_mode, load_valid, load_addr, load_data,
    input  dm_dout, load_ready, busy
  );

  modport slave (
    input  dm_ceb, dm_w_en, dm_bweb, dm_addr, dm_din,
    input  load_mode, load_valid, load_addr, load_data,
    output dm_dout, load_ready, busy
  );
endinterface

// File: rtl/dm_storage_array.sv
// Single-port word array: bit-masked synchronous write, registered read.
// Out-of-range addresses read as zero and never write.
module dm_storage_array
  import instruction_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DEPTH  = DM_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [31:0]       bmask_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  localparam int IDX_W = dm_idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      rdata_q;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  assign in_range = {1'b0, addr_i} < DEPTH_L;
  assign idx      = addr_i[IDX_W-1:0];

  always_ff @(posedge clk_i) begin
    if (en_i && we_i && in_range) begin
      mem_q[idx] <= (mem_q[idx] & ~bmask_i) | (wdata_i & bmask_i);
    end
  end

  // Read data only moves on a read; writes leave it untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= in_range ? mem_q[idx] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: zero-fills after reset, accepts preload beats,
// then serves CPU reads/writes through one storage port.
//
// state    | meaning
// ST_CLEAR | counter writes 0 to words 0..DEPTH-1, one per cycle
// ST_LOAD  | load_ready=1, handshaked beats written as full words
// ST_RUN   | CPU port owns the array
module dm_responder
  import instruction_pkg::*;
#(
  parameter int ADDR_W         = DM_ADDR_W,
  parameter int DEPTH          = DM_DEPTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic rst,
  dm_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  dm_state_e         state_q;
  logic [CNT_W-1:0]  clr_cnt_q;
  logic              busy_q;
  logic              load_ready_q;

  logic              load_fire;
  logic              cpu_req;
  logic              port_en;
  logic              port_we;
  logic [31:0]       port_mask;
  logic [ADDR_W-1:0] port_addr;
  logic [31:0]       port_wdata;
  logic [31:0]       rdata;

  assign load_fire = bus.load_valid && load_ready_q;
  assign cpu_req   = !busy_q && !bus.dm_ceb;

  // Port arbitration: clear, then preload, then CPU; nothing while in reset.
  always_comb begin
    port_en    = 1'b0;
    port_we    = 1'b0;
    port_mask  = '0;
    port_addr  = '0;
    port_wdata = '0;
    if (!rst) begin
      port_en = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      port_en    = 1'b1;
      port_we    = 1'b1;
      port_mask  = '1;
      port_addr  = ADDR_W'(clr_cnt_q);
    end else if (load_fire) begin
      port_en    = 1'b1;
      port_we    = 1'b1;
      port_mask  = '1;
      port_addr  = bus.load_addr;
      port_wdata = bus.load_data;
    end else if (cpu_req) begin
      port_en    = 1'b1;
      port_we    = !bus.dm_w_en;
      port_mask  = ~bus.dm_bweb;
      port_addr  = bus.dm_addr;
      port_wdata = bus.dm_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q    <= '0;
      busy_q       <= 1'b1;
      load_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // Terminal count holds the counter at DEPTH-1 rather than wrapping.
          if (clr_cnt_q == CNT_LAST) begin
            if (bus.load_mode) begin
              state_q      <= ST_LOAD;
              load_ready_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
            end
          end else begin
            clr_cnt_q <= clr_cnt_q + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          if (!bus.load_mode) begin
            state_q      <= ST_RUN;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.load_mode) begin
            state_q      <= ST_LOAD;
            busy_q       <= 1'b1;
            load_ready_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          busy_q       <= 1'b0;
          load_ready_q <= 1'b0;
        end
      endcase
    end
  end

  dm_storage_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (port_en),
    .we_i    (port_we),
    .bmask_i (port_mask),
    .addr_i  (port_addr),
    .wdata_i (port_wdata),
    .rdata_o (rdata)
  );

  assign bus.dm_dout    = rdata;
  assign bus.load_ready = load_ready_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with DEPTH=64 and clear-on-reset enabled.
module tb_dm_responder;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  dm_if #(.ADDR_W(ADDR_W)) bus ();

  dm_responder #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input logic [31:0] bweb);
    bus.dm_ceb  = 1'b0;
    bus.dm_w_en = 1'b0;
    bus.dm_addr = ADDR_W'(addr);
    bus.dm_din  = data;
    bus.dm_bweb = bweb;
    tick();
    bus.dm_ceb  = 1'b1;
    bus.dm_w_en = 1'b1;
    bus.dm_bweb = '1;
  endtask

  task automatic do_read(input int addr);
    bus.dm_ceb  = 1'b0;
    bus.dm_w_en = 1'b1;
    bus.dm_addr = ADDR_W'(addr);
    tick();
    bus.dm_ceb  = 1'b1;
  endtask

  // Counts edges until busy drops; optionally pokes a CPU write to addr 7 mid-clear.
  task automatic run_clear(output int cnt, input bit poke7);
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (poke7 && cnt == 20) begin
        bus.dm_ceb  = 1'b0;
        bus.dm_w_en = 1'b0;
        bus.dm_bweb = '0;
        bus.dm_addr = ADDR_W'(7);
        bus.dm_din  = 32'hFFFF_FFFF;
      end else begin
        bus.dm_ceb  = 1'b1;
        bus.dm_w_en = 1'b1;
        bus.dm_bweb = '1;
      end
    end while (bus.busy && cnt < 200);
  endtask

  initial begin
    rst            = 1'b0;
    bus.dm_ceb     = 1'b1;
    bus.dm_w_en    = 1'b1;
    bus.dm_bweb    = '1;
    bus.dm_addr    = '0;
    bus.dm_din     = '0;
    bus.load_mode  = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;

    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
    check("rst_dout", bus.dm_dout, 32'h0);

    rst = 1'b1;
    repeat (30) tick();
    check("mid_clear_busy", 32'(bus.busy), 32'd1);

    rst = 1'b0;
    repeat (2) tick();
    check("rerst_busy", 32'(bus.busy), 32'd1);
    check("rerst_load_ready", 32'(bus.load_ready), 32'd0);

    rst = 1'b1;
    run_clear(n, 1'b1);
    check("clear_cycles", 32'(n), 32'd64);
    check("run_busy", 32'(bus.busy), 32'd0);
    check("run_load_ready", 32'(bus.load_ready), 32'd0);

    do_read(7);
    check("busy_write_dropped", bus.dm_dout, 32'h0);

    do_write(5, 32'hDEAD_BEEF, 32'h0);
    do_read(5);
    check("rd_after_wr", bus.dm_dout, 32'hDEAD_BEEF);

    do_write(6, 32'h1234_5678, 32'h0);
    check("wr_keeps_dout", bus.dm_dout, 32'hDEAD_BEEF);

    do_read(63);
    check("cleared_63", bus.dm_dout, 32'h0);

    do_write(5, 32'h0000_0012, 32'hFFFF_FF00);
    do_read(5);
    check("masked_wr", bus.dm_dout, 32'hDEAD_BE12);

    bus.dm_addr = ADDR_W'(6);
    tick();
    check("idle_hold", bus.dm_dout, 32'hDEAD_BE12);

    do_write(100, 32'hCAFE_F00D, 32'h0);
    do_read(100);
    check("oor_read", bus.dm_dout, 32'h0);
    do_read(36);
    check("oor_no_alias", bus.dm_dout, 32'h0);
    do_read(6);
    check("rd_6", bus.dm_dout, 32'h1234_5678);

    bus.load_mode = 1'b1;
    tick();
    check("load_ready", 32'(bus.load_ready), 32'd1);
    check("load_busy", 32'(bus.busy), 32'd1);

    bus.load_valid = 1'b1;
    bus.load_addr  = ADDR_W'(3);
    bus.load_data  = 32'h1111_1111;
    bus.dm_ceb     = 1'b0;
    bus.dm_w_en    = 1'b1;
    bus.dm_addr    = ADDR_W'(5);
    tick();
    bus.load_valid = 1'b0;
    bus.load_addr  = ADDR_W'(9);
    bus.load_data  = 32'hBADB_AD00;
    bus.dm_ceb     = 1'b0;
    bus.dm_w_en    = 1'b0;
    bus.dm_bweb    = '0;
    bus.dm_addr    = ADDR_W'(10);
    bus.dm_din     = 32'hFFFF_FFFF;
    tick();
    bus.dm_ceb     = 1'b1;
    bus.dm_w_en    = 1'b1;
    bus.dm_bweb    = '1;
    bus.load_valid = 1'b1;
    bus.load_addr  = ADDR_W'(100);
    bus.load_data  = 32'h5555_5555;
    tick();
    bus.load_addr  = ADDR_W'(4);
    bus.load_data  = 32'h2222_2222;
    bus.load_mode  = 1'b0;
    tick();
    bus.load_valid = 1'b0;
    check("post_load_busy", 32'(bus.busy), 32'd0);
    check("post_load_ready", 32'(bus.load_ready), 32'd0);
    check("load_cpu_ignored", bus.dm_dout, 32'h1234_5678);

    do_read(3);
    check("preload_3", bus.dm_dout, 32'h1111_1111);
    do_read(4);
    check("preload_4_last_beat", bus.dm_dout, 32'h2222_2222);
    do_read(9);
    check("no_handshake_9", bus.dm_dout, 32'h0);
    do_read(10);
    check("load_cpu_wr_dropped", bus.dm_dout, 32'h0);
    do_read(36);
    check("preload_oor_dropped", bus.dm_dout, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
